// File: rtl/hdr_target_controller.sv
// hdr_target_controller
//
// Top-level sequencer for the target's HDR-DDR mode. Between HDR entry and
// HDR exit it owns the shared RX/TX frame units and the register-file port.
// It receives the command word, dispatches the transfer to the CCC engine
// (broadcast address 7'h7E) or the normal engine (own dynamic address),
// muxes the granted engine's controls onto the shared units, and recovers
// on restart, exit, RX error or engine hang.
//
// Optional feature macro: HDR_CTRL_WATCHDOG_EN
//   defined   -> watchdog counter aborts a grant after TIMEOUT_CYCLES cycles
//   undefined -> no counter, o_timeout tied low
//
// Ports
//   i_sys_clk, i_sys_rst (async, active-low)
//   i_hdr_en, i_dyn_addr                      HDR mode level, own address
//   i_rx_mode_done, i_rx_error                RX frame-unit status pulses
//   i_rx_cmd_rnw, i_rx_cmd_addr               decoded command-word fields
//   i_restart_done, i_exit_done               restart/exit detector pulses
//   i_ccc_* / i_nrm_*                         engine requests + done
//   o_rx_*, o_tx_*, o_regf_*                  shared unit controls (muxed)
//   o_ccc_en, o_nrm_en, o_cmd_rnw             registered grants, RnW bit
//   o_detector_en, o_timeout, o_hdr_done      registered status

module hdr_target_controller #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 11
) (
    input  logic       i_sys_clk,
    input  logic       i_sys_rst,
    input  logic       i_hdr_en,
    input  logic [6:0] i_dyn_addr,
    input  logic       i_rx_mode_done,
    input  logic       i_rx_error,
    input  logic       i_rx_cmd_rnw,
    input  logic [6:0] i_rx_cmd_addr,
    input  logic       i_restart_done,
    input  logic       i_exit_done,
    input  logic       i_ccc_rx_en,
    input  logic [4:0] i_ccc_rx_mode,
    input  logic       i_ccc_tx_en,
    input  logic [4:0] i_ccc_tx_mode,
    input  logic       i_ccc_regf_wr_en,
    input  logic       i_ccc_regf_rd_en,
    input  logic [7:0] i_ccc_regf_addr,
    input  logic       i_ccc_done,
    input  logic       i_nrm_rx_en,
    input  logic [4:0] i_nrm_rx_mode,
    input  logic       i_nrm_tx_en,
    input  logic [4:0] i_nrm_tx_mode,
    input  logic       i_nrm_regf_wr_en,
    input  logic       i_nrm_regf_rd_en,
    input  logic [7:0] i_nrm_regf_addr,
    input  logic       i_nrm_done,
    output logic       o_rx_en,
    output logic [4:0] o_rx_mode,
    output logic       o_tx_en,
    output logic [4:0] o_tx_mode,
    output logic       o_regf_wr_en,
    output logic       o_regf_rd_en,
    output logic [7:0] o_regf_addr,
    output logic       o_ccc_en,
    output logic       o_nrm_en,
    output logic       o_cmd_rnw,
    output logic       o_detector_en,
    output logic       o_timeout,
    output logic       o_hdr_done
);

    localparam logic [6:0] CCC_BCAST_ADDR = 7'h7E;
    localparam logic [4:0] RX_MODE_PRE    = 5'd0;
    localparam logic [4:0] RX_MODE_CMD    = 5'd9;
    // Last counter value a grant may reach before it is aborted.
    localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD_PRE,
        S_CMD_WORD,
        S_CCC_RUN,
        S_NRM_RUN,
        S_WAIT_RS
    } state_t;

    state_t state_q;
    logic   ccc_en_q;
    logic   nrm_en_q;
    logic   cmd_rnw_q;
    logic   det_en_q;
    logic   timeout_q;
    logic   hdr_done_q;

`ifdef HDR_CTRL_WATCHDOG_EN
    logic [CNT_W-1:0] cnt_q;
`else
    logic unused_limit;
    assign unused_limit = ^TO_LIMIT;
`endif

    // Sequencer with registered grants and status pulses.
    // Priority: hdr_en low > exit > restart > per-state behaviour.
    always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
        if (!i_sys_rst) begin
            state_q    <= S_IDLE;
            ccc_en_q   <= 1'b0;
            nrm_en_q   <= 1'b0;
            cmd_rnw_q  <= 1'b0;
            det_en_q   <= 1'b0;
            timeout_q  <= 1'b0;
            hdr_done_q <= 1'b0;
`ifdef HDR_CTRL_WATCHDOG_EN
            cnt_q      <= '0;
`endif
        end else begin
            timeout_q  <= 1'b0;
            hdr_done_q <= 1'b0;
            if (!i_hdr_en) begin
                // SDR side left HDR without us seeing the exit pattern.
                state_q  <= S_IDLE;
                ccc_en_q <= 1'b0;
                nrm_en_q <= 1'b0;
                det_en_q <= 1'b0;
            end else if (state_q != S_IDLE && i_exit_done) begin
                state_q    <= S_IDLE;
                ccc_en_q   <= 1'b0;
                nrm_en_q   <= 1'b0;
                det_en_q   <= 1'b0;
                hdr_done_q <= 1'b1;
            end else if (state_q != S_IDLE && i_restart_done) begin
                state_q  <= S_CMD_PRE;
                ccc_en_q <= 1'b0;
                nrm_en_q <= 1'b0;
                det_en_q <= 1'b1;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        state_q  <= S_CMD_PRE;
                        det_en_q <= 1'b1;
                    end
                    S_CMD_PRE: begin
                        if (i_rx_error) begin
                            state_q <= S_WAIT_RS;
                        end else if (i_rx_mode_done) begin
                            state_q <= S_CMD_WORD;
                        end
                    end
                    S_CMD_WORD: begin
                        if (i_rx_mode_done) begin
                            cmd_rnw_q <= i_rx_cmd_rnw;
                            if (i_rx_error) begin
                                state_q <= S_WAIT_RS;
                            end else if (i_rx_cmd_addr == CCC_BCAST_ADDR) begin
                                state_q  <= S_CCC_RUN;
                                ccc_en_q <= 1'b1;
`ifdef HDR_CTRL_WATCHDOG_EN
                                cnt_q    <= '0;
`endif
                            end else if (i_rx_cmd_addr == i_dyn_addr) begin
                                state_q  <= S_NRM_RUN;
                                nrm_en_q <= 1'b1;
`ifdef HDR_CTRL_WATCHDOG_EN
                                cnt_q    <= '0;
`endif
                            end else begin
                                // Addressed to another target: sit out until restart/exit.
                                state_q <= S_WAIT_RS;
                            end
                        end else if (i_rx_error) begin
                            state_q <= S_WAIT_RS;
                        end
                    end
                    S_CCC_RUN: begin
                        // Done wins over a timeout landing in the same cycle.
                        if (i_ccc_done) begin
                            state_q  <= S_WAIT_RS;
                            ccc_en_q <= 1'b0;
`ifdef HDR_CTRL_WATCHDOG_EN
                        end else if (cnt_q == TO_LIMIT) begin
                            state_q   <= S_WAIT_RS;
                            ccc_en_q  <= 1'b0;
                            timeout_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
`endif
                        end
                    end
                    S_NRM_RUN: begin
                        if (i_nrm_done) begin
                            state_q  <= S_WAIT_RS;
                            nrm_en_q <= 1'b0;
`ifdef HDR_CTRL_WATCHDOG_EN
                        end else if (cnt_q == TO_LIMIT) begin
                            state_q   <= S_WAIT_RS;
                            nrm_en_q  <= 1'b0;
                            timeout_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
`endif
                        end
                    end
                    S_WAIT_RS: begin
                        state_q <= S_WAIT_RS;
                    end
                    default: begin
                        state_q  <= S_IDLE;
                        ccc_en_q <= 1'b0;
                        nrm_en_q <= 1'b0;
                        det_en_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Shared-unit mux: combinational from state so engine requests reach
    // the RX/TX units and register file with no added latency.
    always_comb begin
        o_rx_en      = 1'b0;
        o_rx_mode    = RX_MODE_PRE;
        o_tx_en      = 1'b0;
        o_tx_mode    = 5'd0;
        o_regf_wr_en = 1'b0;
        o_regf_rd_en = 1'b0;
        o_regf_addr  = 8'd0;
        case (state_q)
            S_CMD_PRE: begin
                o_rx_en   = 1'b1;
                o_rx_mode = RX_MODE_PRE;
            end
            S_CMD_WORD: begin
                o_rx_en   = 1'b1;
                o_rx_mode = RX_MODE_CMD;
            end
            S_CCC_RUN: begin
                o_rx_en      = i_ccc_rx_en;
                o_rx_mode    = i_ccc_rx_mode;
                o_tx_en      = i_ccc_tx_en;
                o_tx_mode    = i_ccc_tx_mode;
                o_regf_wr_en = i_ccc_regf_wr_en;
                o_regf_rd_en = i_ccc_regf_rd_en;
                o_regf_addr  = i_ccc_regf_addr;
            end
            S_NRM_RUN: begin
                o_rx_en      = i_nrm_rx_en;
                o_rx_mode    = i_nrm_rx_mode;
                o_tx_en      = i_nrm_tx_en;
                o_tx_mode    = i_nrm_tx_mode;
                o_regf_wr_en = i_nrm_regf_wr_en;
                o_regf_rd_en = i_nrm_regf_rd_en;
                o_regf_addr  = i_nrm_regf_addr;
            end
            default: begin
            end
        endcase
    end

    assign o_ccc_en      = ccc_en_q;
    assign o_nrm_en      = nrm_en_q;
    assign o_cmd_rnw     = cmd_rnw_q;
    assign o_detector_en = det_en_q;
    assign o_timeout     = timeout_q;
    assign o_hdr_done    = hdr_done_q;

endmodule

// File: tb/tb_hdr_target_controller.sv
// Directed bench for hdr_target_controller. Inputs are driven 1 time unit
// after the rising edge; outputs are sampled at that same point.

module tb_hdr_target_controller;

    localparam int TO = 16;
`ifdef HDR_CTRL_WATCHDOG_EN
    localparam int CCC_LEN = 10;
`else
    localparam int CCC_LEN = 40;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       hdr_en;
    logic [6:0] dyn_addr;
    logic       rx_mode_done, rx_error, rx_cmd_rnw;
    logic [6:0] rx_cmd_addr;
    logic       restart_done, exit_done;
    logic       ccc_rx_en, ccc_tx_en, ccc_wr, ccc_rd, ccc_done;
    logic [4:0] ccc_rx_mode, ccc_tx_mode;
    logic [7:0] ccc_addr;
    logic       nrm_rx_en, nrm_tx_en, nrm_wr, nrm_rd, nrm_done;
    logic [4:0] nrm_rx_mode, nrm_tx_mode;
    logic [7:0] nrm_addr;
    logic       o_rx_en, o_tx_en, o_regf_wr_en, o_regf_rd_en;
    logic [4:0] o_rx_mode, o_tx_mode;
    logic [7:0] o_regf_addr;
    logic       o_ccc_en, o_nrm_en, o_cmd_rnw, o_detector_en, o_timeout, o_hdr_done;

    int total = 0;
    int bad   = 0;

    hdr_target_controller #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
        .i_sys_clk(clk), .i_sys_rst(rst_n), .i_hdr_en(hdr_en), .i_dyn_addr(dyn_addr),
        .i_rx_mode_done(rx_mode_done), .i_rx_error(rx_error),
        .i_rx_cmd_rnw(rx_cmd_rnw), .i_rx_cmd_addr(rx_cmd_addr),
        .i_restart_done(restart_done), .i_exit_done(exit_done),
        .i_ccc_rx_en(ccc_rx_en), .i_ccc_rx_mode(ccc_rx_mode), .i_ccc_tx_en(ccc_tx_en),
        .i_ccc_tx_mode(ccc_tx_mode), .i_ccc_regf_wr_en(ccc_wr), .i_ccc_regf_rd_en(ccc_rd),
        .i_ccc_regf_addr(ccc_addr), .i_ccc_done(ccc_done),
        .i_nrm_rx_en(nrm_rx_en), .i_nrm_rx_mode(nrm_rx_mode), .i_nrm_tx_en(nrm_tx_en),
        .i_nrm_tx_mode(nrm_tx_mode), .i_nrm_regf_wr_en(nrm_wr), .i_nrm_regf_rd_en(nrm_rd),
        .i_nrm_regf_addr(nrm_addr), .i_nrm_done(nrm_done),
        .o_rx_en(o_rx_en), .o_rx_mode(o_rx_mode), .o_tx_en(o_tx_en), .o_tx_mode(o_tx_mode),
        .o_regf_wr_en(o_regf_wr_en), .o_regf_rd_en(o_regf_rd_en), .o_regf_addr(o_regf_addr),
        .o_ccc_en(o_ccc_en), .o_nrm_en(o_nrm_en), .o_cmd_rnw(o_cmd_rnw),
        .o_detector_en(o_detector_en), .o_timeout(o_timeout), .o_hdr_done(o_hdr_done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Stimulus-only helpers.
    task automatic pulse_mode_done();
        rx_mode_done = 1'b1;
        step();
        rx_mode_done = 1'b0;
    endtask

    task automatic pulse_restart();
        restart_done = 1'b1;
        step();
        restart_done = 1'b0;
    endtask

    task automatic send_cmd(input logic [6:0] addr, input logic rnw);
        rx_cmd_addr  = addr;
        rx_cmd_rnw   = rnw;
        rx_mode_done = 1'b1;
        step();
        rx_mode_done = 1'b0;
        rx_cmd_addr  = 7'h00;
        rx_cmd_rnw   = 1'b0;
    endtask

    task automatic test_reset();
        logic [35:0] all_out;
        rst_n = 1'b0;
        hdr_en = 1'b1;
        dyn_addr = 7'h12;
        {rx_mode_done, rx_error, rx_cmd_rnw, rx_cmd_addr, restart_done, exit_done} = '0;
        {ccc_rx_en, ccc_tx_en, ccc_wr, ccc_rd, ccc_done, ccc_rx_mode, ccc_tx_mode, ccc_addr} = '0;
        {nrm_rx_en, nrm_tx_en, nrm_wr, nrm_rd, nrm_done, nrm_rx_mode, nrm_tx_mode, nrm_addr} = '0;
        step(); step();
        all_out = {o_rx_en, o_rx_mode, o_tx_en, o_tx_mode, o_regf_wr_en, o_regf_rd_en, o_regf_addr,
                   o_ccc_en, o_nrm_en, o_cmd_rnw, o_detector_en, o_timeout, o_hdr_done};
        total++; if (all_out !== 36'd0) begin bad++; $display("FAIL reset_outputs got=%h want=0", all_out); end
        hdr_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        total++; if (o_detector_en !== 1'b0) begin bad++; $display("FAIL reset_idle_det got=%b want=0", o_detector_en); end
    endtask

    task automatic test_ccc_broadcast();
        hdr_en = 1'b1;
        step();
        total++; if ({o_rx_en, o_rx_mode, o_detector_en} !== {1'b1, 5'd0, 1'b1}) begin bad++;
            $display("FAIL pre_rx got=%b/%0d/%b want=1/0/1", o_rx_en, o_rx_mode, o_detector_en); end
        pulse_mode_done();
        total++; if ({o_rx_en, o_rx_mode} !== {1'b1, 5'd9}) begin bad++;
            $display("FAIL cmdword_rx got=%b/%0d want=1/9", o_rx_en, o_rx_mode); end
        ccc_rx_en = 1'b1; ccc_rx_mode = 5'h0B; ccc_tx_en = 1'b1; ccc_tx_mode = 5'h15;
        ccc_wr = 1'b1; ccc_rd = 1'b0; ccc_addr = 8'hA5;
        nrm_rx_en = 1'b0; nrm_rx_mode = 5'h02; nrm_tx_en = 1'b0; nrm_tx_mode = 5'h07;
        nrm_wr = 1'b0; nrm_rd = 1'b1; nrm_addr = 8'h3C;
        #1;
        total++; if ({o_tx_en, o_regf_wr_en} !== 2'b00) begin bad++;
            $display("FAIL cmdword_no_tx got=%b want=00", {o_tx_en, o_regf_wr_en}); end
        send_cmd(7'h7E, 1'b0);
        total++; if ({o_ccc_en, o_nrm_en} !== 2'b10) begin bad++;
            $display("FAIL ccc_grant got=%b want=10", {o_ccc_en, o_nrm_en}); end
        total++; if ({o_rx_en, o_rx_mode, o_tx_en, o_tx_mode, o_regf_wr_en, o_regf_rd_en, o_regf_addr}
                     !== {1'b1, 5'h0B, 1'b1, 5'h15, 1'b1, 1'b0, 8'hA5}) begin bad++;
            $display("FAIL ccc_mirror got=%b/%h/%b/%h/%b/%b/%h want=1/0b/1/15/1/0/a5", o_rx_en, o_rx_mode,
                     o_tx_en, o_tx_mode, o_regf_wr_en, o_regf_rd_en, o_regf_addr); end
        ccc_addr = 8'h5A; ccc_wr = 1'b0; ccc_rd = 1'b1; ccc_tx_mode = 5'h04;
        #1;
        total++; if ({o_tx_mode, o_regf_wr_en, o_regf_rd_en, o_regf_addr} !== {5'h04, 1'b0, 1'b1, 8'h5A}) begin bad++;
            $display("FAIL ccc_mirror_live got=%h/%b/%b/%h want=04/0/1/5a", o_tx_mode, o_regf_wr_en, o_regf_rd_en, o_regf_addr); end
        // The normal engine's done must be ignored during a CCC grant.
        nrm_done = 1'b1;
        step();
        nrm_done = 1'b0;
        total++; if (o_ccc_en !== 1'b1) begin bad++; $display("FAIL ccc_ignore_nrm_done got=%b want=1", o_ccc_en); end
        for (int k = 2; k < CCC_LEN; k++) begin
            step();
            total++; if (o_ccc_en !== 1'b1) begin bad++; $display("FAIL ccc_hold cyc=%0d got=%b want=1", k, o_ccc_en); end
        end
        ccc_done = 1'b1;
        step();
        ccc_done = 1'b0;
        total++; if ({o_ccc_en, o_tx_en, o_regf_wr_en, o_regf_rd_en, o_regf_addr, o_detector_en, o_timeout}
                     !== {1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0}) begin bad++;
            $display("FAIL ccc_done_waitrs got=%b/%b/%b/%b/%h/%b/%b want=0/0/0/0/00/1/0", o_ccc_en, o_tx_en,
                     o_regf_wr_en, o_regf_rd_en, o_regf_addr, o_detector_en, o_timeout); end
    endtask

    task automatic test_private_read();
        pulse_restart();
        total++; if ({o_rx_en, o_rx_mode} !== {1'b1, 5'd0}) begin bad++;
            $display("FAIL restart_pre got=%b/%0d want=1/0", o_rx_en, o_rx_mode); end
        pulse_mode_done();
        nrm_tx_en = 1'b1; nrm_tx_mode = 5'h1A; nrm_rx_en = 1'b0; nrm_rd = 1'b1; nrm_wr = 1'b0; nrm_addr = 8'h12;
        send_cmd(7'h12, 1'b1);
        total++; if ({o_nrm_en, o_ccc_en, o_cmd_rnw} !== 3'b101) begin bad++;
            $display("FAIL nrm_grant got=%b want=101", {o_nrm_en, o_ccc_en, o_cmd_rnw}); end
        total++; if ({o_tx_en, o_tx_mode, o_regf_rd_en, o_regf_addr} !== {1'b1, 5'h1A, 1'b1, 8'h12}) begin bad++;
            $display("FAIL nrm_mirror got=%b/%h/%b/%h want=1/1a/1/12", o_tx_en, o_tx_mode, o_regf_rd_en, o_regf_addr); end
        nrm_tx_mode = 5'h03;
        #1;
        total++; if (o_tx_mode !== 5'h03) begin bad++; $display("FAIL nrm_tx_follow got=%h want=03", o_tx_mode); end
        nrm_done = 1'b1;
        step();
        nrm_done = 1'b0;
        total++; if ({o_nrm_en, o_cmd_rnw, o_tx_en} !== 3'b010) begin bad++;
            $display("FAIL nrm_done got=%b want=010", {o_nrm_en, o_cmd_rnw, o_tx_en}); end
    endtask

    task automatic test_foreign_addr();
        pulse_restart();
        pulse_mode_done();
        send_cmd(7'h33, 1'b0);
        total++; if ({o_ccc_en, o_nrm_en, o_cmd_rnw, o_tx_en} !== 4'b0000) begin bad++;
            $display("FAIL foreign_nogrant got=%b want=0000", {o_ccc_en, o_nrm_en, o_cmd_rnw, o_tx_en}); end
        step();
        total++; if ({o_ccc_en, o_nrm_en, o_rx_en, o_detector_en} !== 4'b0001) begin bad++;
            $display("FAIL foreign_waitrs got=%b want=0001", {o_ccc_en, o_nrm_en, o_rx_en, o_detector_en}); end
        pulse_restart();
        total++; if ({o_rx_en, o_rx_mode} !== {1'b1, 5'd0}) begin bad++;
            $display("FAIL foreign_restart got=%b/%0d want=1/0", o_rx_en, o_rx_mode); end
    endtask

    task automatic test_restart_exit_same();
        pulse_mode_done();
        send_cmd(7'h12, 1'b0);
        total++; if (o_nrm_en !== 1'b1) begin bad++; $display("FAIL rx_nrm_grant got=%b want=1", o_nrm_en); end
        restart_done = 1'b1; exit_done = 1'b1;
        step();
        restart_done = 1'b0; exit_done = 1'b0; hdr_en = 1'b0;
        total++; if ({o_hdr_done, o_nrm_en, o_detector_en, o_rx_en} !== 4'b1000) begin bad++;
            $display("FAIL exit_over_restart got=%b want=1000", {o_hdr_done, o_nrm_en, o_detector_en, o_rx_en}); end
        step();
        total++; if ({o_hdr_done, o_rx_en} !== 2'b00) begin bad++;
            $display("FAIL exit_pulse_end got=%b want=00", {o_hdr_done, o_rx_en}); end
    endtask

    task automatic test_hdr_fall();
        hdr_en = 1'b1;
        step();
        pulse_mode_done();
        send_cmd(7'h7E, 1'b1);
        total++; if (o_ccc_en !== 1'b1) begin bad++; $display("FAIL fall_grant got=%b want=1", o_ccc_en); end
        hdr_en = 1'b0;
        step();
        total++; if ({o_ccc_en, o_detector_en, o_hdr_done, o_rx_en} !== 4'b0000) begin bad++;
            $display("FAIL hdr_fall got=%b want=0000", {o_ccc_en, o_detector_en, o_hdr_done, o_rx_en}); end
    endtask

    task automatic test_watchdog();
        hdr_en = 1'b1;
        step();
        pulse_mode_done();
        send_cmd(7'h7E, 1'b0);
`ifdef HDR_CTRL_WATCHDOG_EN
        for (int k = 1; k < TO; k++) begin
            step();
            total++; if ({o_ccc_en, o_timeout} !== 2'b10) begin bad++;
                $display("FAIL wd_hold cyc=%0d got=%b want=10", k, {o_ccc_en, o_timeout}); end
        end
        step();
        total++; if ({o_ccc_en, o_timeout, o_detector_en} !== 3'b011) begin bad++;
            $display("FAIL wd_abort got=%b want=011", {o_ccc_en, o_timeout, o_detector_en}); end
        step();
        total++; if (o_timeout !== 1'b0) begin bad++; $display("FAIL wd_pulse_end got=%b want=0", o_timeout); end
        // Done landing exactly on the limit cycle is a normal completion.
        pulse_restart();
        pulse_mode_done();
        send_cmd(7'h7E, 1'b0);
        for (int k = 1; k < TO; k++) step();
        ccc_done = 1'b1;
        step();
        ccc_done = 1'b0;
        total++; if ({o_ccc_en, o_timeout} !== 2'b00) begin bad++;
            $display("FAIL wd_done_at_limit got=%b want=00", {o_ccc_en, o_timeout}); end
`else
        for (int k = 1; k <= 3 * TO; k++) begin
            step();
            total++; if ({o_ccc_en, o_timeout} !== 2'b10) begin bad++;
                $display("FAIL nowd_hold cyc=%0d got=%b want=10", k, {o_ccc_en, o_timeout}); end
        end
        ccc_done = 1'b1;
        step();
        ccc_done = 1'b0;
        total++; if ({o_ccc_en, o_timeout} !== 2'b00) begin bad++;
            $display("FAIL nowd_done got=%b want=00", {o_ccc_en, o_timeout}); end
`endif
        exit_done = 1'b1;
        step();
        exit_done = 1'b0; hdr_en = 1'b0;
        total++; if ({o_hdr_done, o_detector_en} !== 2'b10) begin bad++;
            $display("FAIL waitrs_exit got=%b want=10", {o_hdr_done, o_detector_en}); end
        step();
    endtask

    task automatic test_reset_mid_run();
        logic [35:0] all_out;
        hdr_en = 1'b1;
        step();
        pulse_mode_done();
        ccc_rx_en = 1'b1; ccc_tx_en = 1'b1; ccc_wr = 1'b1; ccc_addr = 8'hC3; ccc_tx_mode = 5'h11;
        send_cmd(7'h7E, 1'b1);
        total++; if ({o_ccc_en, o_tx_en, o_cmd_rnw} !== 3'b111) begin bad++;
            $display("FAIL rst_pre_grant got=%b want=111", {o_ccc_en, o_tx_en, o_cmd_rnw}); end
        #2 rst_n = 1'b0;
        #1;
        all_out = {o_rx_en, o_rx_mode, o_tx_en, o_tx_mode, o_regf_wr_en, o_regf_rd_en, o_regf_addr,
                   o_ccc_en, o_nrm_en, o_cmd_rnw, o_detector_en, o_timeout, o_hdr_done};
        total++; if (all_out !== 36'd0) begin bad++; $display("FAIL async_reset got=%h want=0", all_out); end
        hdr_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        total++; if ({o_rx_en, o_detector_en, o_ccc_en} !== 3'b000) begin bad++;
            $display("FAIL post_reset_idle got=%b want=000", {o_rx_en, o_detector_en, o_ccc_en}); end
    endtask

    initial begin
        test_reset();
        test_ccc_broadcast();
        test_private_read();
        test_foreign_addr();
        test_restart_exit_same();
        test_hdr_fall();
        test_watchdog();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
